// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 4-way round-robin dispatcher.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/demux4_dispatch_if.sv
// Producer stream, per-channel consumer handshakes and demux select of the dispatcher.
interface demux4_dispatch_if #(
  parameter int unsigned WIDTH = 8
);
  import demux_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [NUM_CH-1:0] chan_en;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  // Environment side: producer, consumers and channel enables.
  modport master (
    output in_valid, in_data, chan_en, out_ready,
    input  in_ready, out_valid, out_data, sel, busy
  );

  // Dispatcher side.
  modport slave (
    input  in_valid, in_data, chan_en, out_ready,
    output in_ready, out_valid, out_data, sel, busy
  );

endinterface

// File: rtl/demux4_dispatch_rr_pick.sv
// Rotate-priority picker: first enabled channel at or after ptr, wrapping modulo NUM_CH.
module rr_pick
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] en,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  target,
  output logic              found
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest enabled channel wins.
  always_comb begin
    target = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (en[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux4_dispatch.sv
// Buffers one input word and steers it to the next enabled output channel in rotating order.
module demux4_dispatch
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  demux4_dispatch_if.slave   bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [SEL_W-1:0] pick;
  logic             found;
  logic             deliver;
  logic             ready;
  logic             accept;

  rr_pick u_pick (
    .en     (bus.chan_en),
    .ptr    (ptr_q),
    .target (pick),
    .found  (found)
  );

  // Only the selected consumer's ready matters; others are ignored.
  assign deliver = (state_q == HOLD) && bus.out_ready[sel_q];
  assign ready   = !rst && ((state_q == IDLE) || deliver) && found;
  assign accept  = bus.in_valid && ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (accept) begin
      state_d = HOLD;
      sel_d   = pick;
      ptr_d   = pick + SEL_W'(1);
      data_d  = bus.in_data;
    end else if (deliver) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.out_valid = '0;
    if (state_q == HOLD) begin
      bus.out_valid[sel_q] = 1'b1;
    end
  end

  assign bus.in_ready = ready;
  assign bus.out_data = data_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q == HOLD);

endmodule
